riscv_int_prio_controller: RTL and testbench
============================================

// Module: riscv_int_prio_controller
// PURPOSE
//  Multi-line successor of the single-line core interrupt controller. Accepts NUM_IRQ lines with
//  per-line mask, mode (level/edge) and secure bit. Arbitrates by fixed priority (lowest index wins)
//  and presents one request (id, sec) to the core controller with the same ack/kill handshake.
//  Adds edge latching and re-arbitration while a request is pending.
// PARAMETERS
//  NUM_IRQ      32  number of interrupt lines, 1..32
//  ID_W         5   id width; must equal (NUM_IRQ>1 ? $clog2(NUM_IRQ) : 1)
//  PULP_SECURE  0   1: enable depends on privilege level and secure bit; 0: m_IE_i only
//  EDGE_SUPPORT 1   0: irq_edge_i ignored, all lines level-sensitive, edge logic removed
// PORTS
//  clk                 in   1        core clock; single clock domain
//  rst_n               in   1        reset, synchronous, active-low
//  irq_i               in   NUM_IRQ  interrupt lines
//  irq_edge_i          in   NUM_IRQ  per-line mode: 1=rising-edge, 0=level
//  irq_mask_i          in   NUM_IRQ  per-line enable: 1=enabled
//  irq_sec_i           in   NUM_IRQ  per-line secure bit
//  m_IE_i              in   1        global enable, M mode
//  u_IE_i              in   1        global enable, U mode
//  current_priv_lvl_i  in   PrivLvl_t current privilege level
//  irq_req_ctrl_o      out  1        request to controller, high in PENDING
//  irq_sec_ctrl_o      out  1        secure bit of presented id
//  irq_id_ctrl_o       out  ID_W     presented interrupt id
//  ctrl_ack_i          in   1        controller took the interrupt
//  ctrl_kill_i         in   1        controller dropped the request
//  irq_pending_o       out  NUM_IRQ  effective pending vector (pend & mask), for CSR read
// BEHAVIOUR
//  - Reset: synchronous. Any posedge clk with rst_n=0 clears every register. State=IDLE;
//    irq_req_ctrl_o=0, irq_sec_ctrl_o=0, irq_id_ctrl_o=0, irq_pending_o=0, edge latches=0,
//    irq_q=0. Reset in PENDING/DONE returns to IDLE and loses latched edges.
//  - Edge: irq_q <= irq_i every cycle. Edge line i: edge_pend_q[i] set when irq_i[i] & ~irq_q[i].
//    A line already high at reset release counts as an edge on the first cycle.
//  - pend[i] = irq_edge_i[i] ? edge_pend_q[i] : irq_i[i]. irq_pending_o = pend & irq_mask_i (comb).
//  - Enable per line: PULP_SECURE=1: ((u_IE_i|irq_sec_i[i]) & priv==U) | (m_IE_i & priv==M);
//    otherwise m_IE_i. req = pend & mask & enable. win_id = lowest set index of req.
//  - FSM (states IDLE, IRQ_PENDING, IRQ_DONE):
//    IDLE: |req -> IRQ_PENDING next cycle, id_q<=win_id, sec_q<=irq_sec_i[win_id]. Latency 1 cycle
//      from line to irq_req_ctrl_o (2 cycles for edge lines: latch, then capture).
//    IRQ_PENDING: ack -> IRQ_DONE and clear edge_pend_q[id_q]. kill -> IDLE, nothing cleared.
//      ack and kill together: ack wins. Neither: if |req and win_id<id_q, update id_q/sec_q
//      (re-arbitration); request stays high. Presented line withdrawn: stays pending (sticky).
//    IRQ_DONE: sec_q<=0, -> IDLE unconditionally. No capture in DONE: 1 idle bubble after each ack.
//  - New edge on line id_q in the cycle it is acked: set wins, the line stays pending.
//  - id_q changes only in IDLE capture or PENDING re-arbitration. Never changes in an ack cycle.
//  - Index arithmetic: win_id zero-extended to ID_W. Bits >= NUM_IRQ do not exist.
// STRUCTURE
//  - riscv_defines: add typedef enum logic[1:0] int_ctrl_state_e {INT_IDLE,INT_PENDING,INT_DONE}.
//    Reuse existing PrivLvl_t / PRIV_LVL_U / PRIV_LVL_M.
//  - Sub-module riscv_int_prio_enc #(NUM_IRQ,ID_W): comb req vector -> valid, id (lowest index).
//  - Top holds irq_q, edge_pend_q, FSM, id_q, sec_q.
// TESTING
//  1 Reset: rst_n=0 with irq_i=all ones for 2 clk -> all outputs 0. Release, level lines, mask
//    bit 3 only, m_IE=1 -> next cycle req=1, id=3.
//  2 Priority/rearb: lines 9 and 20 level, PENDING id=20, no ack. Raise line 4 -> next cycle
//    id=4. Ack -> DONE, then IDLE. Line 9 still high -> PENDING id=9 after 1 bubble.
//  3 Edge: line 7 edge mode, 1-cycle pulse -> pend[7] stays 1. Ack id=7 -> pend[7]=0. Second
//    pulse in the ack cycle -> pend[7] stays 1.
//  4 Kill/ack collision: PENDING id=2 edge. kill -> IDLE, pend[2] still 1, re-request id=2.
//    ack+kill together -> DONE, pend[2]=0.
//  5 Secure: PULP_SECURE=1, priv=U, u_IE=0, line 5 sec=1 and line 1 sec=0 pending ->
//    id=5, sec_ctrl=1. priv=M, m_IE=0 -> no request.
//  6 Mid-op reset: rst_n=0 for 1 clk while PENDING with edges latched -> IDLE, pending=0.

Source files
------------

// File: rtl/riscv_int_prio_controller_pkg.sv
// Shared types for the multi-line interrupt priority controller.
// Privilege levels follow the core encoding. The controller state names match the core controller.
package riscv_int_prio_controller_pkg;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_H = 2'b10,
      PRIV_LVL_M = 2'b11
   } PrivLvl_t;

   typedef enum logic [1:0] {
      INT_IDLE    = 2'b00,
      INT_PENDING = 2'b01,
      INT_DONE    = 2'b10
   } int_ctrl_state_e;

endpackage

// File: rtl/riscv_int_prio_controller_enc.sv
// Fixed-priority encoder. The lowest set index of the request vector wins.
module riscv_int_prio_enc
   import riscv_int_prio_controller_pkg::*;
#(
   parameter int NUM_IRQ = 32,
   parameter int ID_W    = 5
) (
   input  logic [NUM_IRQ-1:0] req_i,
   output logic               valid_o,
   output logic [ID_W-1:0]    id_o
);

   // Scan from the top down so that the last hit is the lowest index.
   always_comb begin
      valid_o = |req_i;
      id_o    = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         id_o = req_i[i] ? ID_W'(i) : id_o;
      end
   end

endmodule

// File: rtl/riscv_int_prio_controller.sv
// Multi-line interrupt controller. It latches edges, masks and enables lines, and picks the
// winner by fixed priority. It presents one request with an ack/kill handshake and re-arbitrates while pending.
module riscv_int_prio_controller
   import riscv_int_prio_controller_pkg::*;
#(
   parameter int NUM_IRQ      = 32,
   parameter int ID_W         = 5,
   parameter int PULP_SECURE  = 0,
   parameter int EDGE_SUPPORT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [NUM_IRQ-1:0] irq_edge_i,
   input  logic [NUM_IRQ-1:0] irq_mask_i,
   input  logic [NUM_IRQ-1:0] irq_sec_i,
   input  logic               m_IE_i,
   input  logic               u_IE_i,
   input  PrivLvl_t           current_priv_lvl_i,
   output logic               irq_req_ctrl_o,
   output logic               irq_sec_ctrl_o,
   output logic [ID_W-1:0]    irq_id_ctrl_o,
   input  logic               ctrl_ack_i,
   input  logic               ctrl_kill_i,
   output logic [NUM_IRQ-1:0] irq_pending_o
);

   int_ctrl_state_e    state_q, state_d;
   logic [NUM_IRQ-1:0] irq_q, irq_d;
   logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               sec_q, sec_d;

   logic [NUM_IRQ-1:0] pend_s;
   logic [NUM_IRQ-1:0] en_s;
   logic [NUM_IRQ-1:0] req_s;
   logic [NUM_IRQ-1:0] clr_mask_s;
   logic               win_valid_s;
   logic [ID_W-1:0]    win_id_s;
   logic               win_sec_s;
   logic               ack_fire_s;

   riscv_int_prio_enc #(
      .NUM_IRQ (NUM_IRQ),
      .ID_W    (ID_W)
   ) u_enc (
      .req_i   (req_s),
      .valid_o (win_valid_s),
      .id_o    (win_id_s)
   );

   // Per-line pending and enable qualification, plus the secure bit of the current winner.
   always_comb begin
      pend_s    = '0;
      en_s      = '0;
      win_sec_s = 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (EDGE_SUPPORT != 0) begin
            pend_s[i] = irq_edge_i[i] ? edge_pend_q[i] : irq_i[i];
         end else begin
            pend_s[i] = irq_i[i];
         end
         if (PULP_SECURE != 0) begin
            en_s[i] = ((u_IE_i | irq_sec_i[i]) & (current_priv_lvl_i == PRIV_LVL_U)) |
                      (m_IE_i & (current_priv_lvl_i == PRIV_LVL_M));
         end else begin
            en_s[i] = m_IE_i;
         end
         win_sec_s = (ID_W'(i) == win_id_s) ? irq_sec_i[i] : win_sec_s;
      end
      req_s         = pend_s & irq_mask_i & en_s;
      irq_pending_o = pend_s & irq_mask_i;
   end

   // Edge latch. A new rising edge in the ack cycle overrides the clear of the acked line.
   always_comb begin
      irq_d      = irq_i;
      ack_fire_s = (state_q == INT_PENDING) & ctrl_ack_i;
      clr_mask_s = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         clr_mask_s[i] = ack_fire_s & (ID_W'(i) == id_q);
      end
      if (EDGE_SUPPORT != 0) begin
         edge_pend_d = (edge_pend_q & ~clr_mask_s) | (irq_i & ~irq_q);
      end else begin
         edge_pend_d = '0;
      end
   end

   // Request FSM: capture, re-arbitrate, and handle the handshake.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      sec_d   = sec_q;
      case (state_q)
         INT_IDLE: begin
            if (win_valid_s) begin
               state_d = INT_PENDING;
               id_d    = win_id_s;
               sec_d   = win_sec_s;
            end else begin
               state_d = INT_IDLE;
            end
         end
         INT_PENDING: begin
            if (ctrl_ack_i) begin
               state_d = INT_DONE;
            end else if (ctrl_kill_i) begin
               state_d = INT_IDLE;
            end else if (win_valid_s && (win_id_s < id_q)) begin
               id_d  = win_id_s;
               sec_d = win_sec_s;
            end else begin
               state_d = INT_PENDING;
            end
         end
         INT_DONE: begin
            sec_d   = 1'b0;
            state_d = INT_IDLE;
         end
         default: begin
            state_d = INT_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= INT_IDLE;
         irq_q       <= '0;
         edge_pend_q <= '0;
         id_q        <= '0;
         sec_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         irq_q       <= irq_d;
         edge_pend_q <= edge_pend_d;
         id_q        <= id_d;
         sec_q       <= sec_d;
      end
   end

   assign irq_req_ctrl_o = (state_q == INT_PENDING);
   assign irq_sec_ctrl_o = sec_q;
   assign irq_id_ctrl_o  = id_q;

endmodule

// File: tb/tb_riscv_int_prio_controller.sv
// Directed bench for riscv_int_prio_controller. The main instance is secure. A second, non-secure
// instance shares the inputs and is checked where the two enable rules differ.
module tb_riscv_int_prio_controller;
   import riscv_int_prio_controller_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] irq, irq_edge, irq_mask, irq_sec;
   logic        m_ie, u_ie, ack, kill;
   PrivLvl_t    priv;

   logic        req, sec;
   logic [4:0]  id;
   logic [31:0] pending;
   logic        req0, sec0;
   logic [4:0]  id0;
   logic [31:0] pending0;

   int n_checks;
   int n_errors;

   riscv_int_prio_controller #(
      .NUM_IRQ(32), .ID_W(5), .PULP_SECURE(1), .EDGE_SUPPORT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_edge_i(irq_edge), .irq_mask_i(irq_mask),
      .irq_sec_i(irq_sec), .m_IE_i(m_ie), .u_IE_i(u_ie), .current_priv_lvl_i(priv),
      .irq_req_ctrl_o(req), .irq_sec_ctrl_o(sec), .irq_id_ctrl_o(id),
      .ctrl_ack_i(ack), .ctrl_kill_i(kill), .irq_pending_o(pending)
   );

   riscv_int_prio_controller #(
      .NUM_IRQ(32), .ID_W(5), .PULP_SECURE(0), .EDGE_SUPPORT(1)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_edge_i(irq_edge), .irq_mask_i(irq_mask),
      .irq_sec_i(irq_sec), .m_IE_i(m_ie), .u_IE_i(u_ie), .current_priv_lvl_i(priv),
      .irq_req_ctrl_o(req0), .irq_sec_ctrl_o(sec0), .irq_id_ctrl_o(id0),
      .ctrl_ack_i(ack), .ctrl_kill_i(kill), .irq_pending_o(pending0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0; irq = 32'h0; irq_edge = 32'h0; irq_mask = 32'h0; irq_sec = 32'h0;
      ack = 1'b0; kill = 1'b0; m_ie = 1'b1; u_ie = 1'b0; priv = PRIV_LVL_M;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      // 1: reset with all lines high, then a single level line 3
      rst_n = 1'b0; irq = 32'hFFFF_FFFF; irq_edge = 32'h0; irq_mask = 32'h0; irq_sec = 32'h0;
      ack = 1'b0; kill = 1'b0; m_ie = 1'b1; u_ie = 1'b0; priv = PRIV_LVL_M;
      tick();
      tick();
      check_eq("t1_rst_req", 32'(req), 32'd0);
      check_eq("t1_rst_id", 32'(id), 32'd0);
      check_eq("t1_rst_sec", 32'(sec), 32'd0);
      check_eq("t1_rst_pend", pending, 32'h0);
      check_eq("t1_rst_req0", 32'(req0), 32'd0);
      rst_n = 1'b1; irq = 32'h0000_0008; irq_mask = 32'h0000_0008;
      #1;
      check_eq("t1_pend_comb", pending, 32'h0000_0008);
      tick();
      check_eq("t1_req", 32'(req), 32'd1);
      check_eq("t1_id", 32'(id), 32'd3);
      check_eq("t1_id0", 32'(id0), 32'd3);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_eq("t1_done_req", 32'(req), 32'd0);

      // 2: priority and re-arbitration on level lines
      reset_dut();
      irq_mask = 32'h0010_0210;
      irq = 32'h0010_0000;
      tick();
      check_eq("t2_id20", 32'(id), 32'd20);
      irq = 32'h0010_0200;
      tick();
      check_eq("t2_rearb9", 32'(id), 32'd9);
      irq = 32'h0010_0210;
      tick();
      check_eq("t2_rearb4_req", 32'(req), 32'd1);
      check_eq("t2_rearb4", 32'(id), 32'd4);
      irq = 32'h0010_0200;
      tick();
      check_eq("t2_sticky_req", 32'(req), 32'd1);
      check_eq("t2_sticky_id", 32'(id), 32'd4);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_eq("t2_done_req", 32'(req), 32'd0);
      check_eq("t2_done_id", 32'(id), 32'd4);
      tick();
      check_eq("t2_bubble_req", 32'(req), 32'd0);
      tick();
      check_eq("t2_next_req", 32'(req), 32'd1);
      check_eq("t2_next_id", 32'(id), 32'd9);

      // 3: edge latching, clear on ack, new edge in ack cycle wins
      reset_dut();
      irq_edge = 32'h0000_0080; irq_mask = 32'h0000_0080;
      tick();
      irq = 32'h0000_0080;
      tick();
      irq = 32'h0;
      check_eq("t3_latched", pending, 32'h0000_0080);
      check_eq("t3_latch_req", 32'(req), 32'd0);
      tick();
      check_eq("t3_req", 32'(req), 32'd1);
      check_eq("t3_id", 32'(id), 32'd7);
      check_eq("t3_still_pend", pending, 32'h0000_0080);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_eq("t3_cleared", pending, 32'h0);
      tick();
      tick();
      check_eq("t3_idle_req", 32'(req), 32'd0);
      irq = 32'h0000_0080;
      tick();
      irq = 32'h0;
      tick();
      check_eq("t3_req2", 32'(req), 32'd1);
      ack = 1'b1; irq = 32'h0000_0080;
      tick();
      ack = 1'b0; irq = 32'h0;
      check_eq("t3_set_wins", pending, 32'h0000_0080);
      tick();
      tick();
      check_eq("t3_rereq", 32'(req), 32'd1);
      check_eq("t3_rereq_id", 32'(id), 32'd7);

      // 4: kill keeps the edge, ack and kill together clears it
      reset_dut();
      irq_edge = 32'h0000_0004; irq_mask = 32'h0000_0004;
      irq = 32'h0000_0004;
      tick();
      irq = 32'h0;
      tick();
      check_eq("t4_req", 32'(req), 32'd1);
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check_eq("t4_kill_req", 32'(req), 32'd0);
      check_eq("t4_kill_pend", pending, 32'h0000_0004);
      tick();
      check_eq("t4_rereq", 32'(req), 32'd1);
      check_eq("t4_rereq_id", 32'(id), 32'd2);
      ack = 1'b1; kill = 1'b1;
      tick();
      ack = 1'b0; kill = 1'b0;
      check_eq("t4_both_req", 32'(req), 32'd0);
      check_eq("t4_both_pend", pending, 32'h0);
      tick();
      tick();
      check_eq("t4_quiet", 32'(req), 32'd0);

      // 5: secure enable in U mode, then M mode with m_IE cleared
      reset_dut();
      priv = PRIV_LVL_U; m_ie = 1'b1; u_ie = 1'b0;
      irq_sec = 32'h0000_0020; irq_mask = 32'h0000_0022; irq = 32'h0000_0022;
      tick();
      check_eq("t5_req", 32'(req), 32'd1);
      check_eq("t5_id", 32'(id), 32'd5);
      check_eq("t5_sec", 32'(sec), 32'd1);
      check_eq("t5_id0", 32'(id0), 32'd1);
      check_eq("t5_sec0", 32'(sec0), 32'd0);
      u_ie = 1'b1;
      tick();
      check_eq("t5_rearb_id", 32'(id), 32'd1);
      check_eq("t5_rearb_sec", 32'(sec), 32'd0);
      reset_dut();
      priv = PRIV_LVL_M; m_ie = 1'b0; u_ie = 1'b1;
      irq_sec = 32'h0000_0020; irq_mask = 32'h0000_0022; irq = 32'h0000_0022;
      tick();
      tick();
      check_eq("t5_m_noreq", 32'(req), 32'd0);
      check_eq("t5_m_noreq0", 32'(req0), 32'd0);

      // 6: reset while pending with edges latched
      reset_dut();
      irq_edge = 32'h0000_0084; irq_mask = 32'h0000_0084;
      irq = 32'h0000_0084;
      tick();
      irq = 32'h0;
      tick();
      check_eq("t6_req", 32'(req), 32'd1);
      check_eq("t6_id", 32'(id), 32'd2);
      rst_n = 1'b0;
      tick();
      check_eq("t6_rst_req", 32'(req), 32'd0);
      check_eq("t6_rst_id", 32'(id), 32'd0);
      check_eq("t6_rst_pend", pending, 32'h0);
      rst_n = 1'b1;
      tick();
      tick();
      check_eq("t6_after_req", 32'(req), 32'd0);
      check_eq("t6_after_pend", pending, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
